sync_fifo_prog: RTL
===================

// Module: sync_fifo_prog
// PURPOSE
//  Single-clock, parametrised FIFO with runtime-programmable almost-full/almost-empty thresholds.
//  Reports occupancy and raises sticky overflow/underflow flags. Selectable standard or
//  first-word-fall-through (FWFT) read mode. All F_DEPTH entries are usable.
//  General buffering block between same-clock producer/consumer stages in the datapath.
// PARAMETERS
//  F_WIDTH      8   data width in bits
//  F_DEPTH      16  entries; power of 2, >=4
//  F_PTR_WIDTH  4   log2(F_DEPTH); pointers are F_PTR_WIDTH+1 bits (wrap bit)
//  FWFT         0   0 = standard registered read, 1 = first-word-fall-through
// PORTS
//  f_clk            in   1              single clock, rising edge
//  f_reset_n        in   1              asynchronous reset, active-low
//  d_in             in   F_WIDTH        write data
//  w_en             in   1              write request
//  r_en             in   1              read request (FWFT: acknowledge of d_out)
//  af_thresh        in   F_PTR_WIDTH+1  almost-full threshold, legal 1..F_DEPTH
//  ae_thresh        in   F_PTR_WIDTH+1  almost-empty threshold, legal 0..F_DEPTH-1
//  err_clr          in   1              synchronous clear of sticky error flags
//  d_out            out  F_WIDTH        read data
//  d_valid          out  1              d_out holds valid read data
//  f_count          out  F_PTR_WIDTH+1  occupancy, 0..F_DEPTH
//  f_full_flag      out  1              f_count==F_DEPTH
//  f_empty_flag     out  1              f_count==0
//  f_half_full_flag out  1              f_count>=F_DEPTH/2
//  f_almost_full_flag  out 1            f_count>=af_thresh
//  f_almost_empty_flag out 1            f_count<=ae_thresh
//  f_overflow       out  1              sticky: write attempted while full
//  f_underflow      out  1              sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (f_reset_n=0, async): pointers, f_count, d_out, d_valid, f_overflow, f_underflow -> 0.
//    Flags follow f_count: empty=1, almost_empty=1, full/half/almost_full=0. Memory not reset.
//    Assertion mid-operation discards contents immediately. Deassertion is synchronised upstream.
//  - Write accepted iff w_en & !f_full_flag: mem[w_ptr]<=d_in, w_ptr+1 on that edge.
//    Read accepted iff r_en & !f_empty_flag: r_ptr+1 on that edge.
//  - Simultaneous accepted read+write: both pointers advance, f_count unchanged.
//    Full + w_en + r_en: read accepted, write rejected, f_overflow set.
//    Empty + w_en + r_en: write accepted, read rejected, f_underflow set.
//  - Pointers wrap modulo 2^(F_PTR_WIDTH+1). Index = low F_PTR_WIDTH bits.
//    f_count = w_ptr - r_ptr, registered (updated on the same edge as the pointers).
//  - Flags decode combinationally from registered f_count and the threshold inputs.
//    af_thresh>F_DEPTH: almost_full never asserts. af_thresh==0 is treated as 1.
//  - FWFT=0: accepted read at edge N -> d_out=mem[r_ptr], d_valid=1 after edge N for one cycle.
//    d_out holds its last value otherwise; it is not zeroed.
//  - FWFT=1: d_out=mem[r_ptr] and d_valid=!f_empty_flag, combinational.
//    Write to an empty FIFO at edge N -> d_valid=1 after edge N. r_en pops the head.
//  - Sticky flags: set on the error cycle; cleared by err_clr on the next edge.
//    If set and clear coincide, set wins.
// STRUCTURE
//  - Shared package fifo_pkg: clog2 function, default width/depth constants,
//    FWFT mode encodings (FIFO_STD=0, FIFO_FWFT=1).
//  - Sub-module fifo_ptr_counter (F_PTR_WIDTH+1 bits, en, f_clk, f_reset_n), instantiated twice
//    (read and write pointers). Memory, count, flags and read mux live in the top module.
// TESTING
//  1. Reset, then write 16 words 0x01..0x10 -> f_full_flag=1, f_count=16, half_full from count 8.
//     17th write -> f_overflow=1, f_count stays 16.
//  2. FWFT=0: read 16 -> d_out 0x01..0x10, each one cycle after r_en with d_valid pulse.
//     Extra read -> f_underflow=1.
//  3. af_thresh=14, ae_thresh=2: fill 0->16->0 -> almost_full asserts at count 14..16;
//     almost_empty asserts at count 0..2.
//  4. Full FIFO, w_en=r_en=1 for 1 cycle -> 1 read, write rejected, f_count=15, overflow set.
//     Steady count=8 with w_en=r_en=1 for 40 cycles -> count stays 8, data order preserved
//     across pointer wrap.
//  5. FWFT=1: write 0xA5 into an empty FIFO -> d_valid=1, d_out=0xA5 the next cycle,
//     before any r_en is asserted.
//  6. Write 5 words, pulse f_reset_n low mid-cycle -> f_count=0, empty=1 immediately.
//     Error flags cleared. err_clr coincident with a new overflow -> flag stays 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO: default sizing,
// read-mode encodings and a constant-evaluable log2 helper.
package fifo_pkg;

    // Ceiling log2, usable when computing parameters.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int FIFO_DEF_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH = 16;

    // Read-mode encodings for the FWFT parameter.
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

endpackage

// File: rtl/fifo_ptr_counter.sv
// Wrapping pointer counter. It carries one bit more than the memory index
// so that full and empty can be told apart when the indices are equal.
module fifo_ptr_counter #(
    parameter int PTR_W = 5
) (
    input  logic             f_clk,
    input  logic             f_reset_n,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Advance by one on an accepted transfer; wraps naturally at 2^PTR_W.
    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge f_clk or negedge f_reset_n) begin
        if (!f_reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// registered occupancy, sticky overflow/underflow and a choice of standard
// or first-word-fall-through read data.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int F_WIDTH     = FIFO_DEF_WIDTH,
    parameter int F_DEPTH     = FIFO_DEF_DEPTH,
    parameter int F_PTR_WIDTH = clog2(FIFO_DEF_DEPTH),
    parameter int FWFT        = FIFO_STD
) (
    input  logic                   f_clk,
    input  logic                   f_reset_n,
    input  logic [F_WIDTH-1:0]     d_in,
    input  logic                   w_en,
    input  logic                   r_en,
    input  logic [F_PTR_WIDTH:0]   af_thresh,
    input  logic [F_PTR_WIDTH:0]   ae_thresh,
    input  logic                   err_clr,
    output logic [F_WIDTH-1:0]     d_out,
    output logic                   d_valid,
    output logic [F_PTR_WIDTH:0]   f_count,
    output logic                   f_full_flag,
    output logic                   f_empty_flag,
    output logic                   f_half_full_flag,
    output logic                   f_almost_full_flag,
    output logic                   f_almost_empty_flag,
    output logic                   f_overflow,
    output logic                   f_underflow
);

    localparam int CW = F_PTR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(F_DEPTH);
    localparam logic [CW-1:0] HALF_C  = CW'(F_DEPTH / 2);

    logic [F_WIDTH-1:0] mem_q [F_DEPTH];

    logic [CW-1:0] w_ptr;
    logic [CW-1:0] r_ptr;
    logic [F_PTR_WIDTH-1:0] w_idx;
    logic [F_PTR_WIDTH-1:0] r_idx;

    logic wr_accept;
    logic rd_accept;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] af_eff;

    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    assign w_idx = w_ptr[F_PTR_WIDTH-1:0];
    assign r_idx = r_ptr[F_PTR_WIDTH-1:0];

    // A write is refused when full and a read when empty; the other side of
    // a simultaneous request still goes through.
    assign wr_accept = w_en && !f_full_flag;
    assign rd_accept = r_en && !f_empty_flag;

    fifo_ptr_counter #(
        .PTR_W     (CW)
    ) u_wr_ptr (
        .f_clk     (f_clk),
        .f_reset_n (f_reset_n),
        .en        (wr_accept),
        .ptr       (w_ptr)
    );

    fifo_ptr_counter #(
        .PTR_W     (CW)
    ) u_rd_ptr (
        .f_clk     (f_clk),
        .f_reset_n (f_reset_n),
        .en        (rd_accept),
        .ptr       (r_ptr)
    );

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge f_clk) begin
        if (wr_accept) begin
            mem_q[w_idx] <= d_in;
        end
    end

    // Occupancy tracks w_ptr - r_ptr and moves on the same edge as the pointers.
    always_comb begin
        count_d = count_q + CW'(wr_accept) - CW'(rd_accept);
    end

    // Occupancy register.
    always_ff @(posedge f_clk or negedge f_reset_n) begin
        if (!f_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A zero almost-full threshold behaves as one; thresholds above the depth
    // can never be reached, so that flag simply stays low.
    always_comb begin
        af_eff = af_thresh;
        if (af_thresh == '0) begin
            af_eff = CW'(1);
        end
    end

    assign f_count             = count_q;
    assign f_full_flag         = (count_q == DEPTH_C);
    assign f_empty_flag        = (count_q == '0);
    assign f_half_full_flag    = (count_q >= HALF_C);
    assign f_almost_full_flag  = (count_q >= af_eff);
    assign f_almost_empty_flag = (count_q <= ae_thresh);

    // Sticky errors: a clear request is overridden by a new error on the same edge.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_en && f_full_flag) begin
            overflow_d = 1'b1;
        end
        if (r_en && f_empty_flag) begin
            underflow_d = 1'b1;
        end
    end

    // Sticky error registers.
    always_ff @(posedge f_clk or negedge f_reset_n) begin
        if (!f_reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign f_overflow  = overflow_q;
    assign f_underflow = underflow_q;

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Head of the queue is always presented; r_en acknowledges and pops it.
            assign d_out   = mem_q[r_idx];
            assign d_valid = !f_empty_flag;
        end else begin : g_std
            logic [F_WIDTH-1:0] dout_q;
            logic [F_WIDTH-1:0] dout_d;
            logic               valid_q;
            logic               valid_d;

            // Capture the popped word; d_out keeps its last value between reads.
            always_comb begin
                dout_d  = dout_q;
                valid_d = rd_accept;
                if (rd_accept) begin
                    dout_d = mem_q[r_idx];
                end
            end

            // Registered read data and its one-cycle valid strobe.
            always_ff @(posedge f_clk or negedge f_reset_n) begin
                if (!f_reset_n) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    dout_q  <= dout_d;
                    valid_q <= valid_d;
                end
            end

            assign d_out   = dout_q;
            assign d_valid = valid_q;
        end
    endgenerate

endmodule
